// File: rtl/decode_stage.sv
// Registered SIMPLE-core decode stage: valid/ready in and out, decoded fields one cycle
// after accept, and a per-register busy scoreboard that interlocks read-after-write hazards.
module decode_stage #(
  parameter int unsigned INSN_W     = 16,
  parameter int unsigned REG_AW     = 3,
  parameter bit          SCOREBOARD = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_ex,
  output logic              ar_mux,
  output logic              br_mux,
  output logic [3:0]        s_alu,
  output logic              input_mux,
  output logic              mem_we,
  output logic              reg_we,
  output logic [REG_AW-1:0] wr_addr,
  output logic              adr_mux,
  output logic              pc_load,
  output logic [2:0]        cond,
  output logic              hazard
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  typedef struct packed {
    logic              sign_ex;
    logic              ar_mux;
    logic              br_mux;
    logic [3:0]        s_alu;
    logic              input_mux;
    logic              mem_we;
    logic              reg_we;
    logic [REG_AW-1:0] wr_addr;
    logic              adr_mux;
    logic              pc_load;
    logic [2:0]        cond;
  } dec_t;

  localparam dec_t DEC_RESET = '{s_alu: 4'b1111, default: '0};

  logic [1:0]        cls;
  logic [3:0]        op;
  logic [4:0]        top5;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [REG_AW-1:0] ra_w;
  logic [REG_AW-1:0] rb_w;
  logic              rd_ra;
  logic              rd_rb;
  logic              ra_busy;
  logic              rb_busy;
  logic              hazard_c;
  logic              accept;
  logic              out_fire;
  logic              unused_insn;
  dec_t              dec;

  dec_t              out_q;
  dec_t              out_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  assign cls         = in_insn[15:14];
  assign op          = in_insn[7:4];
  assign top5        = in_insn[15:11];
  assign ra          = in_insn[13:11];
  assign rb          = in_insn[10:8];
  assign ra_w        = REG_AW'(ra);
  assign rb_w        = REG_AW'(rb);
  assign unused_insn = ^in_insn;

  // Instruction field decode, purely from the presented word.
  always_comb begin
    dec           = DEC_RESET;
    dec.sign_ex   = (cls == 2'b11);
    dec.ar_mux    = ((cls == 2'b11) && (op <= 4'b0110)) || (top5 == 5'b10001);
    dec.br_mux    = !((cls == 2'b10) && in_insn[13]);
    dec.input_mux = (cls == 2'b11) && (op == 4'b1100);
    dec.mem_we    = (cls == 2'b01);
    dec.adr_mux   = ((cls == 2'b11) && (op <= 4'b1011)) || (cls == 2'b10);
    dec.pc_load   = (top5 == 5'b10100) || (top5 == 5'b10111);
    dec.cond      = rb;

    if (cls == 2'b11) begin
      case (op)
        4'b0101: dec.s_alu = 4'b0001;
        4'b0110: dec.s_alu = 4'b1100;
        default: dec.s_alu = op;
      endcase
    end else if (!cls[1]) begin
      dec.s_alu = 4'b0000;
    end else if (top5 == 5'b10000) begin
      dec.s_alu = 4'b1100;
    end else if ((top5 == 5'b10100) || (top5 == 5'b10111)) begin
      dec.s_alu = 4'b0000;
    end else begin
      dec.s_alu = 4'b1111;
    end

    if ((cls == 2'b11) && (op <= 4'b1100)) begin
      dec.reg_we  = 1'b1;
      dec.wr_addr = rb_w;
    end else if (cls == 2'b00) begin
      dec.reg_we  = 1'b1;
      dec.wr_addr = ra_w;
    end else if (top5 == 5'b10000) begin
      dec.reg_we  = 1'b1;
      dec.wr_addr = rb_w;
    end
  end

  assign rd_ra = (cls == 2'b11) || (cls == 2'b01);
  assign rd_rb = (cls == 2'b11) || (cls == 2'b00) || (cls == 2'b01) || (top5 == 5'b10111);

  // A source is blocked by a retiring-later write already issued, or by the one
  // sitting in the output register that has not yet set its busy bit.
  always_comb begin
    ra_busy  = busy_q[ra_w] || (out_valid_q && out_q.reg_we && (out_q.wr_addr == ra_w));
    rb_busy  = busy_q[rb_w] || (out_valid_q && out_q.reg_we && (out_q.wr_addr == rb_w));
    hazard_c = SCOREBOARD && !reset && in_valid &&
               ((rd_ra && ra_busy) || (rd_rb && rb_busy));
  end

  assign hazard   = hazard_c;
  assign in_ready = !reset && !flush && !hazard_c && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (out_fire && out_q.reg_we) begin
      busy_d[out_q.wr_addr] = 1'b1;
    end
    if (!SCOREBOARD) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= DEC_RESET;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign_ex   = out_q.sign_ex;
  assign ar_mux    = out_q.ar_mux;
  assign br_mux    = out_q.br_mux;
  assign s_alu     = out_q.s_alu;
  assign input_mux = out_q.input_mux;
  assign mem_we    = out_q.mem_we;
  assign reg_we    = out_q.reg_we;
  assign wr_addr   = out_q.wr_addr;
  assign adr_mux   = out_q.adr_mux;
  assign pc_load   = out_q.pc_load;
  assign cond      = out_q.cond;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, every cycle checked
// against a behavioural model of the decode rules, handshake and scoreboard.
module tb_decode_stage;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
  logic        sign_ex, ar_mux, br_mux, input_mux, mem_we, reg_we, adr_mux, pc_load, hazard;
  logic [15:0] in_insn;
  logic [2:0]  wb_addr, wr_addr, cond;
  logic [3:0]  s_alu;

  logic        in_valid2, in_ready2, flush2, wb_valid2, out_valid2, out_ready2;
  logic        sign_ex2, ar_mux2, br_mux2, input_mux2, mem_we2, reg_we2, adr_mux2, pc_load2, hazard2;
  logic [15:0] in_insn2;
  logic [3:0]  wb_addr2, wr_addr2, s_alu2;
  logic [2:0]  cond2;

  decode_stage #(.INSN_W(16), .REG_AW(3), .SCOREBOARD(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid),
    .out_ready(out_ready), .sign_ex(sign_ex), .ar_mux(ar_mux), .br_mux(br_mux), .s_alu(s_alu),
    .input_mux(input_mux), .mem_we(mem_we), .reg_we(reg_we), .wr_addr(wr_addr),
    .adr_mux(adr_mux), .pc_load(pc_load), .cond(cond), .hazard(hazard)
  );

  decode_stage #(.INSN_W(16), .REG_AW(4), .SCOREBOARD(1'b0)) dut_nosb (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_insn(in_insn2),
    .flush(flush2), .wb_valid(wb_valid2), .wb_addr(wb_addr2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sign_ex(sign_ex2), .ar_mux(ar_mux2), .br_mux(br_mux2), .s_alu(s_alu2),
    .input_mux(input_mux2), .mem_we(mem_we2), .reg_we(reg_we2), .wr_addr(wr_addr2),
    .adr_mux(adr_mux2), .pc_load(pc_load2), .cond(cond2), .hazard(hazard2)
  );

  typedef struct {
    bit sign_ex, ar_mux, br_mux, input_mux, mem_we, reg_we, adr_mux, pc_load;
    int s_alu, wr_addr, cond;
    bit rd_a, rd_b;
    int ra, rb;
  } ref_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   m_busy [8];
  bit   m_v;
  ref_t m_o;

  function automatic ref_t ref_decode(logic [15:0] w);
    ref_t r;
    int cls, op, top;
    cls  = int'(w[15:14]);
    op   = int'(w[7:4]);
    top  = int'(w[15:11]);
    r.ra = int'(w[13:11]);
    r.rb = int'(w[10:8]);
    r.sign_ex   = (cls == 3);
    r.ar_mux    = (cls == 3 && op <= 6) || top == 17;
    r.br_mux    = !(top >= 20 && top <= 23);
    r.input_mux = (cls == 3 && op == 12);
    r.mem_we    = (cls == 1);
    r.adr_mux   = (cls == 3 && op <= 11) || cls == 2;
    r.pc_load   = (top == 20 || top == 23);
    r.cond      = r.rb;
    if (cls == 3)                 r.s_alu = (op == 5) ? 1 : (op == 6) ? 12 : op;
    else if (cls < 2)             r.s_alu = 0;
    else if (top == 16)           r.s_alu = 12;
    else if (top == 20 || top == 23) r.s_alu = 0;
    else                          r.s_alu = 15;
    r.reg_we  = 1'b1;
    if (cls == 3 && op <= 12)     r.wr_addr = r.rb;
    else if (cls == 0)            r.wr_addr = r.ra;
    else if (top == 16)           r.wr_addr = r.rb;
    else begin r.reg_we = 1'b0;   r.wr_addr = 0; end
    r.rd_a = (cls == 3 || cls == 1);
    r.rd_b = (cls == 3 || cls == 0 || cls == 1 || top == 23);
    return r;
  endfunction

  function automatic ref_t reset_rec();
    ref_t r;
    r = '{default: 0};
    r.s_alu = 15;
    return r;
  endfunction

  function automatic bit blocked(int s);
    return m_busy[s] || (m_v && m_o.reg_we && m_o.wr_addr == s);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_fields(ref_t e);
    chk("sign_ex", sign_ex, e.sign_ex);
    chk("ar_mux", ar_mux, e.ar_mux);
    chk("br_mux", br_mux, e.br_mux);
    chk("s_alu", s_alu, e.s_alu);
    chk("input_mux", input_mux, e.input_mux);
    chk("mem_we", mem_we, e.mem_we);
    chk("reg_we", reg_we, e.reg_we);
    chk("wr_addr", wr_addr, e.wr_addr);
    chk("adr_mux", adr_mux, e.adr_mux);
    chk("pc_load", pc_load, e.pc_load);
    chk("cond", cond, e.cond);
  endtask

  task automatic drive(bit iv, logic [15:0] ins, bit ordy, bit fl, bit wbv, int wba);
    in_valid  = iv;
    in_insn   = ins;
    out_ready = ordy;
    flush     = fl;
    wb_valid  = wbv;
    wb_addr   = 3'(wba);
  endtask

  // One clock of the main DUT: predict, compare, advance the model across the edge.
  task automatic step();
    ref_t d;
    bit   hz, rdy, acc, fire, nv;
    bit   nb [8];
    d    = ref_decode(in_insn);
    hz   = in_valid && ((d.rd_a && blocked(d.ra)) || (d.rd_b && blocked(d.rb)));
    rdy  = !flush && !hz && (!m_v || out_ready);
    acc  = in_valid && rdy;
    fire = m_v && out_ready && !flush;
    nv   = !flush && (acc || (m_v && !out_ready));
    nb   = m_busy;
    if (wb_valid) nb[int'(wb_addr)] = 1'b0;
    if (fire && m_o.reg_we) nb[m_o.wr_addr] = 1'b1;
    #1;
    chk("out_valid", out_valid, m_v);
    chk("in_ready", in_ready, rdy);
    chk("hazard", hazard, hz);
    if (m_v) check_fields(m_o);
    @(posedge clock);
    m_busy = nb;
    m_v    = nv;
    if (acc) m_o = d;
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_hazard", hazard, 0);
    check_fields(reset_rec());
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_v = 1'b0;
    m_o = reset_rec();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(0, 16'h0000, 1, 0, 0, 0);
    in_valid2 = 1'b0; in_insn2 = '0; out_ready2 = 1'b1; flush2 = 1'b0;
    wb_valid2 = 1'b0; wb_addr2 = '0;
    #2;
    @(posedge clock); #1;
    do_reset();

    // Back-to-back independent ALU ops: ADD writes r2, SUB (op 0101) writes r4.
    drive(1, 16'hCA00, 1, 0, 0, 0); step();
    drive(1, 16'hDC50, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 0, 0); step(); step();
    drive(0, 16'h0000, 1, 0, 1, 2); step();
    drive(0, 16'h0000, 1, 0, 1, 4); step();

    // Load into r3, dependent reader stalls until the cycle after writeback.
    drive(1, 16'h1800, 1, 0, 0, 0); step();
    drive(1, 16'hDD00, 1, 0, 0, 0); repeat (6) step();
    drive(1, 16'hDD00, 1, 0, 1, 3); step();
    drive(1, 16'hDD00, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 0, 0); step(); step();
    drive(0, 16'h0000, 1, 0, 1, 5); step();

    // Back-pressure: output held for 5 cycles, then a single fire.
    drive(1, 16'hC900, 1, 0, 0, 0); step();
    drive(1, 16'h0000, 0, 0, 0, 0); repeat (5) step();
    drive(1, 16'h0000, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 0, 0); step(); step();
    drive(0, 16'h0000, 1, 0, 1, 1); step();
    drive(0, 16'h0000, 1, 0, 1, 0); step();

    // Flush drops a write to r5; a reader of r5 then issues freely.
    drive(1, 16'h2800, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 1, 0, 0); step();
    drive(1, 16'hE800, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 0, 0); step(); step();
    drive(0, 16'h0000, 1, 0, 1, 0); step();

    // Fire setting r4 coincides with writeback of r4: set wins, reader stalls; reset clears it.
    drive(1, 16'h2000, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 1, 4); step();
    drive(1, 16'hE000, 1, 0, 0, 0); repeat (3) step();
    do_reset();
    drive(1, 16'hE000, 1, 0, 0, 0); step();
    drive(0, 16'h0000, 1, 0, 0, 0); step(); step();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
      step();
      if (i == 250) do_reset();
    end
    drive(0, 16'h0000, 1, 0, 0, 0); step();

    // No-scoreboard, 4-bit register address build: dependent pair issues back-to-back.
    in_valid2 = 1'b1; in_insn2 = 16'h1800; out_ready2 = 1'b1;
    #1;
    chk("nosb_hazard_a", hazard2, 0);
    chk("nosb_ready_a", in_ready2, 1);
    @(posedge clock); #1;
    in_insn2 = 16'hDD00;
    #1;
    chk("nosb_valid_a", out_valid2, 1);
    chk("nosb_wr_addr_a", wr_addr2, 4'd3);
    chk("nosb_hazard_b", hazard2, 0);
    chk("nosb_ready_b", in_ready2, 1);
    @(posedge clock); #1;
    in_valid2 = 1'b0;
    #1;
    chk("nosb_valid_b", out_valid2, 1);
    chk("nosb_wr_addr_b", wr_addr2, 4'd5);
    chk("nosb_s_alu_b", s_alu2, 4'd0);
    @(posedge clock); #1;
    chk("nosb_drain", out_valid2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
